if_else_emitter: RTL and testbench

Serializes one conditional assignment, `if x <op> C p=A else p=B;`, into a 7-bit ASCII character stream, one character per handshake. It is the transmit-side counterpart of the if/else parser. The emitted stream is directly consumable by that parser, so a test harness or host path can loop statements back through the parser. Operands are captured on a start handshake, and each 32-bit constant is rendered as unsigned decimal by an iterative subtract-powers-of-ten converter.

---
 rtl/if_else_emitter.sv | 350 +++++++++++++++++++++++++++++++++++
 tb/tb_if_else_emitter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_else_emitter.sv
// ============================================================================
// Module   : if_else_emitter
// Brief    : Serializes "if x<op>C p=A else p=B;" as a 7-bit ASCII stream,
//            one character per valid/ready handshake. Constants are rendered
//            as unsigned decimal by iterative subtraction of powers of ten.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module if_else_emitter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  cmp,
    input  logic [31:0] val_c,
    input  logic [31:0] const1,
    input  logic [31:0] const2,
    output logic [6:0]  ascii_char,
    output logic        char_valid,
    input  logic        char_ready,
    output logic        busy,
    output logic        done,
    output logic        error_flag
);

    // ------------------------------------------------------------------------
    // Character codes
    // ------------------------------------------------------------------------
    localparam logic [6:0] c_CH_NUL   = 7'h00;
    localparam logic [6:0] c_CH_SPACE = 7'h20;
    localparam logic [6:0] c_CH_BANG  = 7'h21;
    localparam logic [6:0] c_CH_ZERO  = 7'h30;
    localparam logic [6:0] c_CH_SEMI  = 7'h3B;
    localparam logic [6:0] c_CH_LT    = 7'h3C;
    localparam logic [6:0] c_CH_EQ    = 7'h3D;
    localparam logic [6:0] c_CH_GT    = 7'h3E;
    localparam logic [6:0] c_CH_E     = 7'h65;
    localparam logic [6:0] c_CH_F     = 7'h66;
    localparam logic [6:0] c_CH_I     = 7'h69;
    localparam logic [6:0] c_CH_L     = 7'h6C;
    localparam logic [6:0] c_CH_P     = 7'h70;
    localparam logic [6:0] c_CH_S     = 7'h73;
    localparam logic [6:0] c_CH_X     = 7'h78;

    // Highest valid operator code; 6 and 7 are rejected at start
    localparam logic [2:0] c_CMP_MAX  = 3'd5;
    // Index of the most significant decimal position of a 32-bit value
    localparam logic [3:0] c_K_TOP    = 4'd9;
    // Literal segments: 0 "if x<op>", 1 " p=", 2 " else p=", 3 ";"
    localparam logic [1:0] c_SEG_LAST = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LIT  = 3'd1,
        S_CONV = 3'd2,
        S_DIG  = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t      r_state;
    logic [1:0]  r_seg;     // current literal segment
    logic [3:0]  r_idx;     // character index within the segment
    logic [31:0] r_res;     // conversion residue
    logic [3:0]  r_k;       // current decimal position
    logic [3:0]  r_d;       // digit value accumulated at position r_k
    logic        r_nz;      // a nonzero digit of this number was emitted
    logic [2:0]  r_cmp;
    logic [31:0] r_c;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_err;

    // Next-state values
    state_t      w_state;
    logic [1:0]  w_seg;
    logic [3:0]  w_idx;
    logic [31:0] w_res;
    logic [3:0]  w_k;
    logic [3:0]  w_d;
    logic        w_nz;
    logic [2:0]  w_cmp;
    logic [31:0] w_c;
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic        w_err;

    logic [31:0] w_pow;
    logic [6:0]  w_lit;
    logic [3:0]  w_seg_last;
    logic [31:0] w_operand;

    // ------------------------------------------------------------------------
    // 10^k lookup for k = 0..9
    // ------------------------------------------------------------------------
    function automatic logic [31:0] pow10(input logic [3:0] k);
        case (k)
            4'd0:    pow10 = 32'd1;
            4'd1:    pow10 = 32'd10;
            4'd2:    pow10 = 32'd100;
            4'd3:    pow10 = 32'd1000;
            4'd4:    pow10 = 32'd10000;
            4'd5:    pow10 = 32'd100000;
            4'd6:    pow10 = 32'd1000000;
            4'd7:    pow10 = 32'd10000000;
            4'd8:    pow10 = 32'd100000000;
            4'd9:    pow10 = 32'd1000000000;
            default: pow10 = 32'd1;
        endcase
    endfunction

    // Operators "<" and ">" are one character; all others are two
    function automatic logic op_is_short(input logic [2:0] op);
        op_is_short = (op == 3'd2) || (op == 3'd3);
    endfunction

    // First character of the operator
    function automatic logic [6:0] op_char0(input logic [2:0] op);
        case (op)
            3'd0:    op_char0 = c_CH_EQ;
            3'd1:    op_char0 = c_CH_BANG;
            3'd2:    op_char0 = c_CH_LT;
            3'd3:    op_char0 = c_CH_GT;
            3'd4:    op_char0 = c_CH_LT;
            3'd5:    op_char0 = c_CH_GT;
            default: op_char0 = c_CH_NUL;
        endcase
    endfunction

    // Literal character at (segment, index); two-char operators end in '='
    function automatic logic [6:0] lit_char(input logic [1:0] seg,
                                            input logic [3:0] idx,
                                            input logic [2:0] op);
        lit_char = c_CH_NUL;
        case (seg)
            2'd0: begin
                case (idx)
                    4'd0:    lit_char = c_CH_I;
                    4'd1:    lit_char = c_CH_F;
                    4'd2:    lit_char = c_CH_SPACE;
                    4'd3:    lit_char = c_CH_X;
                    4'd4:    lit_char = op_char0(op);
                    4'd5:    lit_char = c_CH_EQ;
                    default: lit_char = c_CH_NUL;
                endcase
            end
            2'd1: begin
                case (idx)
                    4'd0:    lit_char = c_CH_SPACE;
                    4'd1:    lit_char = c_CH_P;
                    4'd2:    lit_char = c_CH_EQ;
                    default: lit_char = c_CH_NUL;
                endcase
            end
            2'd2: begin
                case (idx)
                    4'd0:    lit_char = c_CH_SPACE;
                    4'd1:    lit_char = c_CH_E;
                    4'd2:    lit_char = c_CH_L;
                    4'd3:    lit_char = c_CH_S;
                    4'd4:    lit_char = c_CH_E;
                    4'd5:    lit_char = c_CH_SPACE;
                    4'd6:    lit_char = c_CH_P;
                    4'd7:    lit_char = c_CH_EQ;
                    default: lit_char = c_CH_NUL;
                endcase
            end
            default: lit_char = c_CH_SEMI;
        endcase
    endfunction

    // Decode the current literal character, segment end index and the
    // number that follows the current segment
    always_comb begin
        w_pow      = pow10(r_k);
        w_lit      = lit_char(r_seg, r_idx, r_cmp);
        w_seg_last = 4'd0;
        w_operand  = r_b;
        case (r_seg)
            2'd0:    w_seg_last = op_is_short(r_cmp) ? 4'd4 : 4'd5;
            2'd1:    w_seg_last = 4'd2;
            2'd2:    w_seg_last = 4'd7;
            default: w_seg_last = 4'd0;
        endcase
        case (r_seg)
            2'd0:    w_operand = r_c;
            2'd1:    w_operand = r_a;
            default: w_operand = r_b;
        endcase
    end

    // Next-state and datapath update logic
    always_comb begin
        w_state = r_state;
        w_seg   = r_seg;
        w_idx   = r_idx;
        w_res   = r_res;
        w_k     = r_k;
        w_d     = r_d;
        w_nz    = r_nz;
        w_cmp   = r_cmp;
        w_c     = r_c;
        w_a     = r_a;
        w_b     = r_b;
        w_err   = r_err;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (cmp <= c_CMP_MAX) begin
                        w_cmp   = cmp;
                        w_c     = val_c;
                        w_a     = const1;
                        w_b     = const2;
                        w_err   = 1'b0;
                        w_seg   = 2'd0;
                        w_idx   = 4'd0;
                        w_state = S_LIT;
                    end else begin
                        w_err   = 1'b1;
                    end
                end
            end

            S_LIT: begin
                if (char_ready) begin
                    if (r_idx == w_seg_last) begin
                        if (r_seg == c_SEG_LAST) begin
                            w_state = S_FIN;
                        end else begin
                            w_res   = w_operand;
                            w_k     = c_K_TOP;
                            w_d     = 4'd0;
                            w_nz    = 1'b0;
                            w_state = S_CONV;
                        end
                    end else begin
                        w_idx = r_idx + 4'd1;
                    end
                end
            end

            S_CONV: begin
                if (r_res >= w_pow) begin
                    // Subtraction is guarded by the compare, so no underflow
                    w_res = r_res - w_pow;
                    w_d   = r_d + 4'd1;
                end else if ((r_d != 4'd0) || r_nz || (r_k == 4'd0)) begin
                    w_state = S_DIG;
                end else begin
                    // Leading zero: suppressed, move to the next position
                    w_k = r_k - 4'd1;
                    w_d = 4'd0;
                end
            end

            S_DIG: begin
                if (char_ready) begin
                    if (r_d != 4'd0) begin
                        w_nz = 1'b1;
                    end
                    if (r_k == 4'd0) begin
                        w_seg   = r_seg + 2'd1;
                        w_idx   = 4'd0;
                        w_state = S_LIT;
                    end else begin
                        w_k     = r_k - 4'd1;
                        w_d     = 4'd0;
                        w_state = S_CONV;
                    end
                end
            end

            S_FIN: begin
                w_state = S_IDLE;
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_seg   <= 2'd0;
            r_idx   <= 4'd0;
            r_res   <= 32'd0;
            r_k     <= 4'd0;
            r_d     <= 4'd0;
            r_nz    <= 1'b0;
            r_cmp   <= 3'd0;
            r_c     <= 32'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state;
            r_seg   <= w_seg;
            r_idx   <= w_idx;
            r_res   <= w_res;
            r_k     <= w_k;
            r_d     <= w_d;
            r_nz    <= w_nz;
            r_cmp   <= w_cmp;
            r_c     <= w_c;
            r_a     <= w_a;
            r_b     <= w_b;
            r_err   <= w_err;
        end
    end

    // Outputs are decoded from registered state so they hold under
    // backpressure and clear as soon as reset is asserted
    always_comb begin
        ascii_char = c_CH_NUL;
        char_valid = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        error_flag = r_err;
        case (r_state)
            S_LIT: begin
                ascii_char = w_lit;
                char_valid = 1'b1;
                busy       = 1'b1;
            end
            S_CONV: begin
                busy       = 1'b1;
            end
            S_DIG: begin
                ascii_char = c_CH_ZERO + {3'b000, r_d};
                char_valid = 1'b1;
                busy       = 1'b1;
            end
            S_FIN: begin
                done       = 1'b1;
            end
            default: begin
                ascii_char = c_CH_NUL;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_if_else_emitter.sv
// ============================================================================
// Module   : tb_if_else_emitter
// Brief    : Self-checking bench for if_else_emitter; the expected stream is
//            formatted directly from the operands and the expected duration
//            is derived from the decimal digits of each operand.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_if_else_emitter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  cmp;
    logic [31:0] val_c;
    logic [31:0] const1;
    logic [31:0] const2;
    logic [6:0]  ascii_char;
    logic        char_valid;
    logic        char_ready;
    logic        busy;
    logic        done;
    logic        error_flag;

    int    n_tests = 0;
    int    n_fail  = 0;
    string got;
    bit    valid_seen;
    int    ndone;
    bit    prev_hold;
    logic [6:0] prev_char;
    bit    rnd_ready;

    string ops [0:5] = '{"==", "!=", "<", ">", "<=", ">="};

    if_else_emitter u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cmp        (cmp),
        .val_c      (val_c),
        .const1     (const1),
        .const2     (const2),
        .ascii_char (ascii_char),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .busy       (busy),
        .done       (done),
        .error_flag (error_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench
    task automatic chk(input string tag, input string obs, input string exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: observed '%s' expected '%s'", tag, obs, exp);
        end
    endtask

    // Sink readiness, updated just after each rising edge
    always @(posedge clk) begin
        #1;
        char_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Sink monitor: collects accepted characters and checks hold behaviour
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold)
                chk("hold", $sformatf("%0d/%0h", char_valid, ascii_char),
                    $sformatf("1/%0h", prev_char));
            if (char_valid && char_ready)
                got = {got, $sformatf("%c", ascii_char)};
            if (char_valid) valid_seen = 1'b1;
            if (done) ndone++;
            prev_hold = char_valid && !char_ready;
            prev_char = ascii_char;
        end
    end

    // Cycles spent on one number: every position costs one cycle plus one per
    // unit of its digit, and every printed digit costs one offer cycle
    function automatic int num_cycles(input logic [31:0] v);
        logic [31:0] t;
        int s;
        int nd;
        t  = v;
        s  = 10;
        nd = 0;
        if (t == 32'd0) return 11;
        while (t != 32'd0) begin
            s  += int'(t % 10);
            nd++;
            t  = t / 10;
        end
        return s + nd;
    endfunction

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 4))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'($urandom_range(0, 999));
            3:       return 32'($urandom_range(0, 9)) * 32'd100000;
            default: return 32'($urandom);
        endcase
    endfunction

    function automatic string out_vec();
        return $sformatf("%0h/%0d/%0d/%0d/%0d", ascii_char, char_valid, busy,
                         done, error_flag);
    endfunction

    // Emit one statement; optional mid-stream start injection or reset
    task automatic run(input logic [2:0] op, input logic [31:0] c,
                       input logic [31:0] a, input logic [31:0] b,
                       input bit rnd, input int inject, input int rstat);
        string exp;
        int    cnt;
        int    done_cyc;
        int    exp_cyc;
        exp       = $sformatf("if x%s%0d p=%0d else p=%0d;", ops[op], c, a, b);
        exp_cyc   = ((op == 3'd2 || op == 3'd3) ? 17 : 18) + num_cycles(c)
                    + num_cycles(a) + num_cycles(b) + 1;
        rnd_ready = rnd;
        @(negedge clk);
        cmp = op; val_c = c; const1 = a; const2 = b; start = 1'b1;
        got = ""; valid_seen = 1'b0; ndone = 0;
        done_cyc = -1;
        cnt = 0;
        while (done_cyc < 0 && cnt < 4000) begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) begin
                start = 1'b0;
                chk("first_cycle", $sformatf("%0d/%0d/%0h/%0d", busy,
                    char_valid, ascii_char, error_flag), "1/1/69/0");
            end
            if (inject > 0 && cnt == inject) begin
                cmp = 3'd1; val_c = 32'd777; const1 = 32'd1; const2 = 32'd2;
                start = 1'b1;
            end
            if (inject > 0 && cnt == inject + 1) start = 1'b0;
            if (rstat > 0 && cnt == rstat) begin
                rst_n = 1'b0;
                #1;
                chk("reset_mid", out_vec(), "0/0/0/0/0");
                repeat (2) @(negedge clk);
                chk("reset_hold", out_vec(), "0/0/0/0/0");
                rst_n = 1'b1;
                return;
            end
            if (done) begin
                done_cyc = cnt;
                chk("busy_at_done", $sformatf("%0d", busy), "0");
            end
        end
        chk("done_seen", $sformatf("%0d", done_cyc > 0), "1");
        if (!rnd) chk("done_cycle", $sformatf("%0d", done_cyc),
                      $sformatf("%0d", exp_cyc));
        @(negedge clk);
        chk("stream", got, exp);
        chk("after_done", $sformatf("%0d/%0d/%0d/%0d", done, busy, char_valid,
            ndone), "0/0/0/1");
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; cmp = 3'd0; val_c = 32'd0;
        const1 = 32'd0; const2 = 32'd0; char_ready = 1'b1; rnd_ready = 1'b0;
        got = ""; valid_seen = 1'b0; ndone = 0; prev_hold = 1'b0;
        prev_char = 7'd0;
        #1;
        chk("reset_state", out_vec(), "0/0/0/0/0");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset", out_vec(), "0/0/0/0/0");

        // All zeros, ready tied high: done lands 52 cycles after start
        run(3'd0, 32'd0, 32'd0, 32'd0, 1'b0, 0, 0);
        // Max constant and internal zeros
        run(3'd5, 32'hFFFF_FFFF, 32'd10, 32'd7, 1'b0, 0, 0);
        // Random backpressure
        run(3'd2, 32'd305, 32'd1000000, 32'd90, 1'b1, 0, 0);

        // Invalid operator: flag only, no characters, no done
        @(negedge clk);
        cmp = 3'd7; start = 1'b1; valid_seen = 1'b0; ndone = 0;
        @(negedge clk);
        start = 1'b0;
        chk("err_rise", $sformatf("%0d/%0d", error_flag, busy), "1/0");
        repeat (60) @(negedge clk);
        chk("err_quiet", $sformatf("%0d/%0d/%0d", valid_seen, ndone,
            error_flag), "0/0/1");
        // Recovery: valid start clears the flag (checked in first cycle)
        run(3'd3, 32'd123, 32'd4, 32'd56, 1'b0, 0, 0);

        // Start while busy is ignored
        run(3'd4, 32'd8675309, 32'd42, 32'd0, 1'b0, 8, 0);
        run(3'd1, 32'd20, 32'd300, 32'd4000, 1'b1, 30, 0);

        // Reset during the C digits, then a fresh statement
        run(3'd0, 32'hFFFF_FFFF, 32'd1, 32'd2, 1'b0, 0, 12);
        run(3'd0, 32'd42, 32'd5, 32'd9, 1'b0, 0, 0);

        // Randomized statements
        for (int i = 0; i < 16; i++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 5));
            run(op, rand_val(), rand_val(), rand_val(), bit'(i % 2), 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
